logic_unit_arbiter: RTL



---
 rtl/logic_unit_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter that shares one registered NOT/AND/OR/XOR
//               logic unit among four requesters (IDLE/EXEC sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [7:0]           req_op,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_id,
    output logic [WIDTH-1:0]     result,
    output logic [15:0]          op_count
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_EXEC = 1'b1;

    localparam logic [1:0] c_OP_NOT = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_OR  = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       done_id_q, done_id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [1:0]       w_op [4];
    logic [WIDTH-1:0] w_a  [4];
    logic [WIDTH-1:0] w_b  [4];
    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_cand;
    logic [WIDTH-1:0] w_alu;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign w_op[i] = req_op[2*i +: 2];
        assign w_a[i]  = req_a[i*WIDTH +: WIDTH];
        assign w_b[i]  = req_b[i*WIDTH +: WIDTH];
    end

    // Search begins one past the last served requester; the 4th probe is last itself.
    always_comb begin
        w_found  = 1'b0;
        w_winner = last_q;
        w_cand   = last_q;
        for (int k = 1; k <= 4; k++) begin
            w_cand = last_q + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        case (op_q)
            c_OP_NOT: w_alu = ~a_q;
            c_OP_AND: w_alu = a_q & b_q;
            c_OP_OR:  w_alu = a_q | b_q;
            default:  w_alu = a_q ^ b_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            last_q     <= 2'd3;
            owner_q    <= 2'd0;
            op_q       <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            gnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 2'd0;
            result_q   <= '0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_found) state_d = c_EXEC;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        gnt_d      = 4'd0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    gnt_d   = 4'b0001 << w_winner;
                    busy_d  = 1'b1;
                    owner_d = w_winner;
                    op_d    = w_op[w_winner];
                    a_d     = w_a[w_winner];
                    b_d     = w_b[w_winner];
                end
            end
            default: begin
                result_d   = w_alu;
                done_d     = 1'b1;
                done_id_d  = owner_q;
                last_d     = owner_q;
                op_count_d = op_count_q + 16'd1;
            end
        endcase
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign result   = result_q;
    assign op_count = op_count_q;

endmodule
`default_nettype wire
